// File: rtl/mul_ctrl_pkg.sv
// Shared definitions for the shift-add multiplier controller: the state
// encoding, the datapath select encodings, the default operand width and a
// helper that decodes the Moore outputs of each state.
package mul_ctrl_pkg;

  // Default multiplier operand width (number of add/shift iterations)
  localparam int MUL_WIDTH = 32;

  // Controller states, kept in a 2-bit register
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } mul_state_e;

  // Operand / product register source selects
  localparam logic SEL_LOAD = 1'b1;
  localparam logic SEL_PATH = 1'b0;

  // Product update select: take the adder output or hold
  localparam logic ADD_ON   = 1'b0;
  localparam logic ADD_HOLD = 1'b1;

  // Bundle of state-decoded controller outputs
  typedef struct packed {
    logic busy;
    logic done;
    logic a_sel;
    logic b_sel;
    logic prod_sel;
    logic add_sel;
  } ctrl_out_t;

  // Width of an iteration counter able to hold 0..w-1 (at least one bit)
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // Moore output decode for a given state; add_sel in RUN is overridden
  // combinationally by the controller from the B register LSB
  function automatic ctrl_out_t decode_state(input mul_state_e s);
    ctrl_out_t o;
    o.busy     = 1'b0;
    o.done     = 1'b0;
    o.a_sel    = SEL_LOAD;
    o.b_sel    = SEL_LOAD;
    o.prod_sel = SEL_PATH;
    o.add_sel  = ADD_HOLD;
    case (s)
      LOAD: begin
        o.busy     = 1'b1;
        o.prod_sel = SEL_LOAD;
      end
      RUN: begin
        o.busy  = 1'b1;
        o.a_sel = SEL_PATH;
        o.b_sel = SEL_PATH;
      end
      DONE: begin
        o.done = 1'b1;
      end
      default: begin
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mul_controller_counter.sv
// Iteration counter for the multiplier controller. Counts RUN cycles with a
// synchronous clear and an enable, and flags the last iteration (WIDTH-1).
module mul_iter_counter
  import mul_ctrl_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic terminal_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority over the increment
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register, zeroed by the asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign terminal_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mul_controller.sv
// Sequencing FSM for the shift-add multiplier datapath: IDLE -> LOAD -> RUN
// (WIDTH iterations) -> DONE. All datapath selects and the Shift_Enable toggle
// strobe come from here. Optional build macro MUL_ABORT_EN adds an Abort input
// that returns LOAD/RUN to IDLE without a Done pulse.
module mul_controller
  import mul_ctrl_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Start,
  input  logic oB_LSB,
`ifdef MUL_ABORT_EN
  input  logic Abort,
`endif
  output logic Busy,
  output logic Done,
  output logic a_sel,
  output logic b_sel,
  output logic prod_sel,
  output logic add_sel,
  output logic Shift_Enable
);

  localparam int CNT_W = cnt_width(WIDTH);

  mul_state_e state_q;
  mul_state_e state_d;
  ctrl_out_t  out_q;
  logic       shift_en_q;
  logic       cnt_last;
  logic       cnt_clear;
  logic       cnt_enable;
  logic       abort_req;

`ifdef MUL_ABORT_EN
  assign abort_req = Abort && ((state_q == LOAD) || (state_q == RUN));
`else
  assign abort_req = 1'b0;
`endif

  // Counter is zeroed while loading and advances once per RUN cycle; it
  // stops at the terminal value so it never wraps inside an operation
  assign cnt_clear  = (state_q == LOAD);
  assign cnt_enable = (state_q == RUN) && !cnt_last;

  mul_iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk_i      (Clock),
    .rst_ni     (Reset),
    .clear_i    (cnt_clear),
    .enable_i   (cnt_enable),
    .terminal_o (cnt_last)
  );

  // Next-state selection; Start only matters in IDLE, abort wins in LOAD/RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (Start) state_d = LOAD;
      LOAD: state_d = RUN;
      RUN:  if (cnt_last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_req) begin
      state_d = IDLE;
    end
  end

  // State, registered Moore outputs and the Shift_Enable toggle strobe
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      out_q      <= decode_state(IDLE);
      shift_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= decode_state(state_d);
      if (state_q == RUN) begin
        shift_en_q <= ~shift_en_q;
      end
    end
  end

  assign Busy         = out_q.busy;
  assign Done         = out_q.done;
  assign a_sel        = out_q.a_sel;
  assign b_sel        = out_q.b_sel;
  assign prod_sel     = out_q.prod_sel;
  assign add_sel      = (state_q == RUN) ? ~oB_LSB : out_q.add_sel;
  assign Shift_Enable = shift_en_q;

endmodule

// File: doc/mul_controller.md
# mul_controller

Sequencing FSM for the 32-bit shift-add multiplier datapath. It accepts a Start request, loads operands, and clears the product register. It then runs one add/shift iteration per clock for WIDTH cycles, choosing add or hold from the multiplier LSB, and flags completion. It sits beside the datapath and drives all of the datapath's select and shift-enable inputs.

## Interface
Parameters:
- WIDTH, 32: multiplier operand width; sets the number of RUN iterations.
- CNT_W, $clog2(WIDTH): local parameter; width of the iteration counter.

Ports:
- Clock  in  1  sole clock; rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled only in IDLE.
- oB_LSB  in  1  LSB of the datapath B register.
- Busy  out  1  high in LOAD and RUN.
- Done  out  1  one-cycle pulse in DONE; product valid.
- a_sel  out  1  1 = load Data_A into A register, 0 = shifted A.
- b_sel  out  1  1 = load Data_B into B register, 0 = shifted B.
- prod_sel  out  1  1 = clear product register, 0 = adder/hold path.
- add_sel  out  1  0 = product takes adder output, 1 = product holds.
- Shift_Enable  out  1  toggle strobe to the shifters.
- Abort  in  1  present only with MUL_ABORT_EN.

## Operation
- States: IDLE, LOAD, RUN, DONE, held in a 2-bit state register.
- IDLE:
  - a_sel=1, b_sel=1, prod_sel=0, add_sel=1; the product register holds its last result.
  - Start=1 -> LOAD.
- LOAD (one cycle):
  - a_sel=1, b_sel=1, prod_sel=1.
  - The next edge loads A and B and zeroes Prod.
  - Counter is cleared to 0. Next state is RUN.
- RUN:
  - a_sel=0, b_sel=0, prod_sel=0.
  - add_sel = ~oB_LSB (Mealy): if the LSB is 1, the product accumulates A; otherwise it holds.
  - A shifts left and B shifts right on the same edge.
  - Counter increments every cycle. When counter == WIDTH-1 -> DONE.
- DONE (one cycle):
  - Done=1, add_sel=1, prod_sel=0. Next state is IDLE.
- Shift_Enable inverts on every RUN cycle and holds its level in all other states. The shifters are level-change triggered, so this re-evaluates them each iteration.
- Start is ignored outside IDLE. Start held high gives back-to-back operations: DONE -> IDLE -> LOAD.
- Arithmetic: product = A×B over 64 bits with no overflow. Counter width is CNT_W and never wraps inside an operation.
- Reset (asserted at any time, including mid-RUN):
  - State goes to IDLE, counter to 0, Shift_Enable to 0, Done to 0, Busy to 0.
  - The datapath's own reset clears its registers. The controller does not restart the operation.

## Timing
- Cycle numbering:
  - Cycle 0: Start is seen high in IDLE.
  - Cycle 1: LOAD.
  - Cycles 2..WIDTH+1: RUN.
  - Cycle WIDTH+2: DONE, with Prod valid.
- Start-to-Done latency is WIDTH+2 cycles (34 for WIDTH=32).
- Minimum Start-to-Start period is WIDTH+3 cycles.
- Reset values of outputs: Busy=0, Done=0, a_sel=1, b_sel=1, prod_sel=0, add_sel=1, Shift_Enable=0.
- Prod remains valid and stable from DONE until the next LOAD.
- All outputs are decoded from state, except add_sel in RUN, which is combinational on oB_LSB.

## Configuration
- MUL_ABORT_EN:
  - Defined: adds the Abort input. Abort=1 in LOAD or RUN -> IDLE on the next edge with no Done pulse. Prod contents are then undefined partial. Abort in IDLE or DONE has no effect.
  - Undefined: no Abort port; an operation always runs to DONE.

## Structure
- Package mul_ctrl_pkg holds:
  - the state enum (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3);
  - the select encodings SEL_LOAD=1'b1, SEL_PATH=1'b0, ADD_ON=1'b0, ADD_HOLD=1'b1;
  - the default operand width constant.
- Sub-module mul_iter_counter: CNT_W-bit counter with synchronous clear and enable, and a terminal flag at WIDTH-1. The FSM is inline in mul_controller.

## Test plan
- Basic multiply: A=3, B=5, one-cycle Start -> Busy for 33 cycles, Done pulse in cycle 34, Prod=64'd15. add_sel=0 in exactly 2 RUN cycles.
- Zero multiplier: A=32'hFFFFFFFF, B=0 -> add_sel=1 in every RUN cycle, Prod=0 at Done. Shift_Enable toggles 32 times.
- Maximum operands: A=B=32'hFFFFFFFF -> Prod=64'hFFFFFFFE00000001 at cycle 34.
- Start during Busy: pulse Start in cycle 10 -> ignored, a single Done at cycle 34. Start held continuously -> Done pulses every 35 cycles.
- Mid-operation reset: Reset low in cycle 15 -> all outputs at reset values immediately. After release, IDLE, and no Done until a new Start.
- Abort (MUL_ABORT_EN defined): Abort in cycle 20 -> IDLE at cycle 21, Busy low, no Done pulse. The next Start completes normally with a correct product.
